// File: rtl/display_arbiter_if.sv
// display_arbiter_if: source, display-driver and status signals around the display arbiter.
// lamp_test exists only when DISP_LAMP_TEST_EN is defined.
interface display_arbiter_if #(
  parameter int unsigned BUNDLE_W = 101
);
  logic                frame_done;
  logic                req0;
  logic [BUNDLE_W-1:0] bundle0;
  logic                valid0;
  logic                req1;
  logic [BUNDLE_W-1:0] bundle1;
  logic                valid1;
  logic [2:0]          dim_level;
`ifdef DISP_LAMP_TEST_EN
  logic                lamp_test;
`endif
  logic                gnt0;
  logic                gnt1;
  logic [BUNDLE_W-1:0] disp_bundle;
  logic                disp_valid;
  logic                blank;
  logic                frame_timeout;

  modport master (
`ifdef DISP_LAMP_TEST_EN
    output lamp_test,
`endif
    output frame_done, req0, bundle0, valid0, req1, bundle1, valid1, dim_level,
    input  gnt0, gnt1, disp_bundle, disp_valid, blank, frame_timeout
  );

  modport slave (
`ifdef DISP_LAMP_TEST_EN
    input  lamp_test,
`endif
    input  frame_done, req0, bundle0, valid0, req1, bundle1, valid1, dim_level,
    output gnt0, gnt1, disp_bundle, disp_valid, blank, frame_timeout
  );
endinterface

// File: rtl/display_arbiter.sv
// display_arbiter: frame-boundary arbiter, coherent snapshot latch, frame-blanking dimmer and driver watchdog.
// Optional DISP_LAMP_TEST_EN adds lamp_test, forcing an all-ones, unblanked, valid frame.
module display_arbiter #(
  parameter int unsigned BUNDLE_W    = 101,
  parameter int unsigned HOLD_FRAMES = 4,
  parameter int unsigned TIMEOUT_CYC = 2**20
) (
  input logic              clk,
  input logic              rst,
  display_arbiter_if.slave bus
);
  localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {NONE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} own_e;

  own_e                state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [2:0]          frame_idx_q, frame_idx_d;
  logic [CNT_W-1:0]    cyc_q;
  logic                gnt0_q, gnt1_q, disp_valid_q, blank_q, timeout_q;
  logic [BUNDLE_W-1:0] disp_bundle_q;
  logic                snap_valid, blank_d;
  logic [BUNDLE_W-1:0] snap_bundle;

  // Ownership state register; everything advances only on frame_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= NONE;
      hold_q      <= '0;
      frame_idx_q <= '0;
    end else if (bus.frame_done) begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      frame_idx_q <= frame_idx_d;
    end
  end

  // Next owner: src1 keeps the display through its hold window, then priority src1 > src0.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    frame_idx_d = frame_idx_q + 3'd1;
    if (state_q == OWN1 && hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end else if (bus.req1) begin
      state_d = OWN1;
      if (state_q != OWN1) hold_d = HOLD_W'(HOLD_FRAMES - 1);
    end else if (bus.req0) begin
      state_d = OWN0;
    end else begin
      state_d = NONE;
    end
  end

  // Snapshot source follows the new owner; lamp test overrides owner and dimming.
  always_comb begin
    snap_valid  = 1'b0;
    snap_bundle = bus.bundle0;
    blank_d     = frame_idx_d < bus.dim_level;
    case (state_d)
      OWN0:    snap_valid = bus.valid0;
      OWN1: begin
        snap_valid  = bus.valid1;
        snap_bundle = bus.bundle1;
      end
      default: snap_valid = 1'b0;
    endcase
`ifdef DISP_LAMP_TEST_EN
    if (bus.lamp_test) begin
      snap_valid  = 1'b1;
      snap_bundle = '1;
      blank_d     = 1'b0;
    end
`endif
  end

  // Registered outputs and the saturating stall watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      disp_valid_q  <= 1'b0;
      disp_bundle_q <= '0;
      blank_q       <= 1'b0;
      timeout_q     <= 1'b0;
      cyc_q         <= '0;
    end else if (bus.frame_done) begin
      gnt0_q       <= (state_d == OWN0);
      gnt1_q       <= (state_d == OWN1);
      disp_valid_q <= snap_valid;
      if (snap_valid) disp_bundle_q <= snap_bundle;
      blank_q      <= blank_d;
      cyc_q        <= '0;
    end else if (cyc_q != CNT_W'(TIMEOUT_CYC)) begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (cyc_q == CNT_W'(TIMEOUT_CYC - 1)) timeout_q <= 1'b1;
    end
  end

  assign bus.gnt0          = gnt0_q;
  assign bus.gnt1          = gnt1_q;
  assign bus.disp_bundle   = disp_bundle_q;
  assign bus.disp_valid    = disp_valid_q;
  assign bus.blank         = blank_q;
  assign bus.frame_timeout = timeout_q;
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed and randomized checks of display_arbiter against a frame-level model.
// Define DISP_LAMP_TEST_EN for both bench and RTL to exercise the lamp test.
module tb_display_arbiter;
  localparam int unsigned BW   = 101;
  localparam int unsigned HOLD = 4;
  localparam int unsigned TO   = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  display_arbiter_if #(.BUNDLE_W(BW)) bus ();

  display_arbiter #(.BUNDLE_W(BW), .HOLD_FRAMES(HOLD), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: owner 0=none, 1=src0, 2=src1; m_hold = extra frames src1 is still guaranteed.
  int          m_own, m_hold, m_idx, m_cnt;
  logic        m_gnt0, m_gnt1, m_dv, m_blank, m_to;
  logic [BW-1:0] m_bundle;

  task automatic model_step();
    logic v;
    logic [BW-1:0] b;
    if (rst) begin
      m_own = 0; m_hold = 0; m_idx = 0; m_cnt = 0;
      m_gnt0 = 0; m_gnt1 = 0; m_dv = 0; m_blank = 0; m_to = 0; m_bundle = '0;
    end else if (bus.frame_done) begin
      m_cnt = 0;
      if (m_own == 2 && m_hold > 0) m_hold = m_hold - 1;
      else if (bus.req1) begin
        if (m_own != 2) m_hold = HOLD - 1;
        m_own = 2;
      end else if (bus.req0) m_own = 1;
      else m_own = 0;
      m_gnt0 = (m_own == 1);
      m_gnt1 = (m_own == 2);
      v = (m_own == 1) ? bus.valid0 : (m_own == 2) ? bus.valid1 : 1'b0;
      b = (m_own == 2) ? bus.bundle1 : bus.bundle0;
      m_idx = (m_idx + 1) % 8;
      m_blank = (m_idx < int'(bus.dim_level));
`ifdef DISP_LAMP_TEST_EN
      if (bus.lamp_test) begin
        v = 1'b1; b = '1; m_blank = 1'b0;
      end
`endif
      m_dv = v;
      if (v) m_bundle = b;
    end else begin
      if (m_cnt < TO) m_cnt = m_cnt + 1;
      if (m_cnt == TO) m_to = 1'b1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
  endtask

  task automatic test_reset();
    bus.req0 = 1; bus.req1 = 1; bus.valid0 = 1; bus.valid1 = 1; bus.frame_done = 1;
    rst = 1;
    tick(); tick();
    rst = 0; bus.frame_done = 0; bus.req0 = 0; bus.req1 = 0;
    total++; if ({bus.gnt0, bus.gnt1} !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", {bus.gnt0, bus.gnt1}); end
    total++; if (bus.disp_bundle !== '0) begin bad++; $display("FAIL reset_bundle got=%h exp=0", bus.disp_bundle); end
    total++; if ({bus.disp_valid, bus.blank, bus.frame_timeout} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {bus.disp_valid, bus.blank, bus.frame_timeout}); end
  endtask

  task automatic test_grant_src0();
    logic [BW-1:0] p;
    p = BW'({4{32'h12345678}});
    bus.req0 = 1; bus.valid0 = 1; bus.bundle0 = p; bus.valid1 = 0;
    tick();
    total++; if (bus.gnt0 !== 1'b0) begin bad++; $display("FAIL pre_frame_gnt0 got=%b exp=0", bus.gnt0); end
    frame();
    total++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin bad++; $display("FAIL grant0 got=%b exp=10", {bus.gnt0, bus.gnt1}); end
    total++; if (bus.disp_bundle !== p) begin bad++; $display("FAIL grant0_bundle got=%h exp=%h", bus.disp_bundle, p); end
    total++; if (bus.disp_valid !== 1'b1) begin bad++; $display("FAIL grant0_valid got=%b exp=1", bus.disp_valid); end
  endtask

  task automatic test_preempt_hold();
    int frames1;
    bus.req1 = 1; bus.valid1 = 1; bus.bundle1 = BW'({4{32'hcafe0001}});
    for (int i = 0; i < 3; i++) tick();
    total++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin bad++; $display("FAIL midframe_no_change got=%b exp=10", {bus.gnt0, bus.gnt1}); end
    frame();
    bus.req1 = 0;
    frames1 = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.gnt1 === 1'b1) frames1++;
      total++; if ({bus.gnt0, bus.gnt1} !== {m_gnt0, m_gnt1}) begin bad++; $display("FAIL hold_frame%0d got=%b exp=%b", i, {bus.gnt0, bus.gnt1}, {m_gnt0, m_gnt1}); end
      frame();
    end
    total++; if (frames1 !== 4) begin bad++; $display("FAIL hold_len got=%0d exp=4", frames1); end
    total++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin bad++; $display("FAIL after_hold got=%b exp=10", {bus.gnt0, bus.gnt1}); end
  endtask

  task automatic test_invalid_idle();
    logic [BW-1:0] prev;
    prev = bus.disp_bundle;
    bus.valid0 = 0; bus.bundle0 = BW'({4{32'hdeadbeef}});
    frame();
    total++; if (bus.disp_valid !== 1'b0) begin bad++; $display("FAIL invalid_valid got=%b exp=0", bus.disp_valid); end
    total++; if (bus.disp_bundle !== prev) begin bad++; $display("FAIL invalid_bundle got=%h exp=%h", bus.disp_bundle, prev); end
    bus.req0 = 0; bus.req1 = 0; bus.valid0 = 1;
    frame();
    total++; if ({bus.gnt0, bus.gnt1, bus.disp_valid} !== 3'b000) begin bad++; $display("FAIL idle got=%b exp=000", {bus.gnt0, bus.gnt1, bus.disp_valid}); end
    total++; if (bus.disp_bundle !== prev) begin bad++; $display("FAIL idle_bundle got=%h exp=%h", bus.disp_bundle, prev); end
  endtask

  task automatic test_dimming();
    int nb;
    bus.dim_level = 3'd3;
    frame();
    nb = 0;
    for (int i = 0; i < 16; i++) begin
      frame();
      if (bus.blank === 1'b1) nb++;
      total++; if (bus.blank !== m_blank) begin bad++; $display("FAIL dim3_blank i=%0d got=%b exp=%b", i, bus.blank, m_blank); end
    end
    total++; if (nb !== 6) begin bad++; $display("FAIL dim3_count got=%0d exp=6", nb); end
    bus.dim_level = 3'd0;
    frame();
    nb = 0;
    for (int i = 0; i < 16; i++) begin
      frame();
      if (bus.blank !== 1'b0) nb++;
    end
    total++; if (nb !== 0) begin bad++; $display("FAIL dim0_count got=%0d exp=0", nb); end
  endtask

`ifdef DISP_LAMP_TEST_EN
  task automatic test_lamp_test();
    bus.lamp_test = 1; bus.dim_level = 3'd7; bus.req0 = 1; bus.valid0 = 0; bus.req1 = 0;
    frame();
    total++; if (bus.disp_bundle !== {BW{1'b1}}) begin bad++; $display("FAIL lamp_bundle got=%h", bus.disp_bundle); end
    total++; if ({bus.disp_valid, bus.blank, bus.gnt0} !== 3'b101) begin bad++; $display("FAIL lamp_flags got=%b exp=101", {bus.disp_valid, bus.blank, bus.gnt0}); end
    bus.req1 = 1;
    frame();
    total++; if ({bus.gnt0, bus.gnt1, bus.blank} !== 3'b010) begin bad++; $display("FAIL lamp_gnt1 got=%b exp=010", {bus.gnt0, bus.gnt1, bus.blank}); end
    bus.lamp_test = 0; bus.dim_level = 3'd0; bus.req0 = 0; bus.req1 = 0; bus.valid0 = 1;
    frame();
  endtask
`endif

  task automatic test_random();
    int gap;
    gap = 0;
    for (int c = 0; c < 600; c++) begin
      bus.req0   = ($urandom_range(0, 3) != 0);
      bus.req1   = ($urandom_range(0, 4) == 0);
      bus.valid0 = ($urandom_range(0, 5) != 0);
      bus.valid1 = ($urandom_range(0, 5) != 0);
      bus.bundle0 = BW'({$urandom(), $urandom(), $urandom(), $urandom()});
      bus.bundle1 = BW'({$urandom(), $urandom(), $urandom(), $urandom()});
      if ($urandom_range(0, 15) == 0) bus.dim_level = 3'($urandom_range(0, 7));
`ifdef DISP_LAMP_TEST_EN
      bus.lamp_test = ($urandom_range(0, 9) == 0);
`endif
      bus.frame_done = ($urandom_range(0, 3) == 0) || (gap >= 30);
      gap = bus.frame_done ? 0 : gap + 1;
      tick();
      bus.frame_done = 0;
      total++; if ({bus.gnt0, bus.gnt1} !== {m_gnt0, m_gnt1}) begin bad++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, {bus.gnt0, bus.gnt1}, {m_gnt0, m_gnt1}); end
      total++; if (bus.disp_bundle !== m_bundle) begin bad++; $display("FAIL rnd_bundle c=%0d got=%h exp=%h", c, bus.disp_bundle, m_bundle); end
      total++; if ({bus.disp_valid, bus.blank, bus.frame_timeout} !== {m_dv, m_blank, m_to}) begin bad++; $display("FAIL rnd_flags c=%0d got=%b exp=%b", c, {bus.disp_valid, bus.blank, bus.frame_timeout}, {m_dv, m_blank, m_to}); end
    end
`ifdef DISP_LAMP_TEST_EN
    bus.lamp_test = 0;
`endif
  endtask

  task automatic test_watchdog();
    logic [1:0] g;
    bus.req0 = 1; bus.req1 = 0; bus.valid0 = 1;
    rst = 1; tick(); rst = 0;
    frame();
    g = {bus.gnt0, bus.gnt1};
    bus.req0 = 0; bus.req1 = 1;
    for (int i = 0; i < TO - 1; i++) tick();
    total++; if (bus.frame_timeout !== 1'b0) begin bad++; $display("FAIL wd_early got=%b exp=0", bus.frame_timeout); end
    tick();
    total++; if (bus.frame_timeout !== 1'b1) begin bad++; $display("FAIL wd_fire got=%b exp=1", bus.frame_timeout); end
    for (int i = 0; i < 20; i++) tick();
    total++; if ({bus.gnt0, bus.gnt1, bus.frame_timeout} !== {g, 1'b1}) begin bad++; $display("FAIL wd_frozen got=%b exp=%b", {bus.gnt0, bus.gnt1, bus.frame_timeout}, {g, 1'b1}); end
    frame();
    total++; if ({bus.gnt1, bus.frame_timeout} !== 2'b11) begin bad++; $display("FAIL wd_sticky got=%b exp=11", {bus.gnt1, bus.frame_timeout}); end
    rst = 1; tick(); rst = 0;
    total++; if (bus.frame_timeout !== 1'b0) begin bad++; $display("FAIL wd_rst got=%b exp=0", bus.frame_timeout); end
  endtask

  initial begin
    bus.frame_done = 0; bus.req0 = 0; bus.req1 = 0; bus.valid0 = 0; bus.valid1 = 0;
    bus.bundle0 = '0; bus.bundle1 = '0; bus.dim_level = 3'd0;
`ifdef DISP_LAMP_TEST_EN
    bus.lamp_test = 0;
`endif
    test_reset();
    test_grant_src0();
    test_preempt_hold();
    test_invalid_idle();
    test_dimming();
`ifdef DISP_LAMP_TEST_EN
    test_lamp_test();
`endif
    test_random();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
